// File: rtl/hazard_pkg.sv
// Shared constants and the scoreboard entry type for the hazard/forwarding unit.
package hazard_pkg;

  // Forward-select value that picks the register file (no forwarding).
  localparam int FWD_RF = 0;

  // Result latencies, counted in stages after ID, for the common producers.
  localparam int LAT_ALU  = 1;
  localparam int LAT_LOAD = 2;

  // Default field widths of one scoreboard entry.
  localparam int SB_RADDR_W = 5;
  localparam int SB_LAT_W   = 3;

  // One in-flight register writer. The top keeps its entries as parametrised
  // field arrays. This struct is the default-width view of the same record.
  typedef struct packed {
    logic                  v;
    logic [SB_RADDR_W-1:0] rd;
    logic [SB_LAT_W-1:0]   lat;
  } sb_entry_t;

endpackage

// File: rtl/hazard_match.sv
// Youngest-producer finder plus readiness check for one ID source operand.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int NSTAGES = 3,
  parameter int LAT_W   = SB_LAT_W,
  parameter int RADDR_W = SB_RADDR_W,
  parameter int SEL_W   = 2
) (
  input  logic [RADDR_W-1:0]         rs_i,
  input  logic                       use_i,
  input  logic [NSTAGES-1:0]         v_i,
  input  logic [NSTAGES*RADDR_W-1:0] rd_i,
  input  logic [NSTAGES*LAT_W-1:0]   lat_i,
  output logic [SEL_W-1:0]           sel_o,
  output logic                       hazard_o
);

  logic             found;
  int               match_k;
  logic [LAT_W-1:0] match_lat;

  // Scan oldest to youngest so the last hit, the smallest stage index, wins.
  always_comb begin
    found     = 1'b0;
    match_k   = 0;
    match_lat = '0;
    for (int k = NSTAGES; k >= 1; k--) begin
      if (use_i && (rs_i != '0) && v_i[k-1] &&
          (rd_i[(k-1)*RADDR_W +: RADDR_W] == rs_i)) begin
        found     = 1'b1;
        match_k   = k;
        match_lat = lat_i[(k-1)*LAT_W +: LAT_W];
      end
    end
    // A producer in stage k has its result only once k reaches its latency.
    hazard_o = found && (match_k < int'(match_lat));
    sel_o    = (found && !hazard_o) ? SEL_W'(match_k) : SEL_W'(FWD_RF);
  end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Scoreboard-based stall, flush and forward-select generator for operands read in ID.
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int NSTAGES = 3,
  parameter int LAT_W   = SB_LAT_W,
  parameter int RADDR_W = SB_RADDR_W,
  parameter int SEL_W   = 2,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [RADDR_W-1:0] rs1_id,
  input  logic [RADDR_W-1:0] rs2_id,
  input  logic               rs1use_id,
  input  logic               rs2use_id,
  input  logic [RADDR_W-1:0] rd_id,
  input  logic               regwrite_id,
  input  logic [LAT_W-1:0]   lat_id,
  input  logic               branch_taken_id,
  input  logic               freeze,
  output logic               pc_en,
  output logic               fd_en,
  output logic               fd_flush,
  output logic               de_flush,
  output logic [SEL_W-1:0]   fwd_sel_a,
  output logic [SEL_W-1:0]   fwd_sel_b,
  output logic [CNT_W-1:0]   stall_cnt
);

  // Entry k-1 in each array describes the instruction now in stage k.
  logic [NSTAGES-1:0]         v_q, v_d;
  logic [NSTAGES*RADDR_W-1:0] rd_q, rd_d;
  logic [NSTAGES*LAT_W-1:0]   lat_q, lat_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;

  logic hazard_a, hazard_b;
  logic stall;

  hazard_match #(
    .NSTAGES(NSTAGES), .LAT_W(LAT_W), .RADDR_W(RADDR_W), .SEL_W(SEL_W)
  ) u_match_a (
    .rs_i    (rs1_id),
    .use_i   (rs1use_id),
    .v_i     (v_q),
    .rd_i    (rd_q),
    .lat_i   (lat_q),
    .sel_o   (fwd_sel_a),
    .hazard_o(hazard_a)
  );

  hazard_match #(
    .NSTAGES(NSTAGES), .LAT_W(LAT_W), .RADDR_W(RADDR_W), .SEL_W(SEL_W)
  ) u_match_b (
    .rs_i    (rs2_id),
    .use_i   (rs2use_id),
    .v_i     (v_q),
    .rd_i    (rd_q),
    .lat_i   (lat_q),
    .sel_o   (fwd_sel_b),
    .hazard_o(hazard_b)
  );

  assign stall = id_valid && (hazard_a || hazard_b);

  // Pipeline controls: freeze masks all of them; a stall also masks the branch.
  always_comb begin
    pc_en    = !freeze && !stall;
    fd_en    = !freeze && !stall;
    de_flush = !freeze && stall;
    fd_flush = !freeze && !stall && branch_taken_id;
  end

  // Next scoreboard: hold on freeze, otherwise shift and load a bubble or the ID instruction.
  always_comb begin
    v_d   = v_q;
    rd_d  = rd_q;
    lat_d = lat_q;
    cnt_d = cnt_q;
    if (!freeze) begin
      for (int k = NSTAGES - 1; k >= 1; k--) begin
        v_d[k]                    = v_q[k-1];
        rd_d[k*RADDR_W +: RADDR_W] = rd_q[(k-1)*RADDR_W +: RADDR_W];
        lat_d[k*LAT_W +: LAT_W]    = lat_q[(k-1)*LAT_W +: LAT_W];
      end
      if (stall) begin
        v_d[0]             = 1'b0;
        rd_d[RADDR_W-1:0]  = '0;
        lat_d[LAT_W-1:0]   = '0;
        if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        v_d[0]            = id_valid && regwrite_id && (rd_id != '0);
        rd_d[RADDR_W-1:0] = rd_id;
        // A zero latency would mark the result ready in ID itself; treat it as one.
        lat_d[LAT_W-1:0]  = (lat_id == '0) ? LAT_W'(1) : lat_id;
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= '0;
      rd_q  <= '0;
      lat_q <= '0;
      cnt_q <= '0;
    end else begin
      v_q   <= v_d;
      rd_q  <= rd_d;
      lat_q <= lat_d;
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit: vector table plus a reset-during-stall sequence.
module tb_hazard_scoreboard_unit;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [4:0] rs1_id, rs2_id, rd_id;
  logic       rs1use_id, rs2use_id, regwrite_id;
  logic [2:0] lat_id;
  logic       branch_taken_id, freeze;

  logic        pc_en, fd_en, fd_flush, de_flush;
  logic [1:0]  fwd_sel_a, fwd_sel_b;
  logic [31:0] stall_cnt;

  // Second copy with a 2-bit counter so saturation is reachable.
  logic       s_pc_en, s_fd_en, s_fd_flush, s_de_flush;
  logic [1:0] s_fwd_sel_a, s_fwd_sel_b;
  logic [1:0] s_stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_scoreboard_unit dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1use_id(rs1use_id), .rs2use_id(rs2use_id),
    .rd_id(rd_id), .regwrite_id(regwrite_id), .lat_id(lat_id),
    .branch_taken_id(branch_taken_id), .freeze(freeze),
    .pc_en(pc_en), .fd_en(fd_en), .fd_flush(fd_flush), .de_flush(de_flush),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .stall_cnt(stall_cnt)
  );

  hazard_scoreboard_unit #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1use_id(rs1use_id), .rs2use_id(rs2use_id),
    .rd_id(rd_id), .regwrite_id(regwrite_id), .lat_id(lat_id),
    .branch_taken_id(branch_taken_id), .freeze(freeze),
    .pc_en(s_pc_en), .fd_en(s_fd_en), .fd_flush(s_fd_flush), .de_flush(s_de_flush),
    .fwd_sel_a(s_fwd_sel_a), .fwd_sel_b(s_fwd_sel_b), .stall_cnt(s_stall_cnt)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic [2:0] lat;
    logic       br;
    logic       frz;
    logic       e_en;
    logic       e_fdfl;
    logic       e_de;
    logic [1:0] e_sa;
    logic [1:0] e_sb;
    int         e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int iv, int rs1, int u1, int rs2, int u2, int rd, int rw,
                              int lat, int br, int frz,
                              int e_en, int e_fdfl, int e_de, int e_sa, int e_sb, int e_cnt);
    vec_t t;
    t.iv = 1'(iv);   t.rs1 = 5'(rs1); t.u1 = 1'(u1); t.rs2 = 5'(rs2); t.u2 = 1'(u2);
    t.rd = 5'(rd);   t.rw = 1'(rw);   t.lat = 3'(lat); t.br = 1'(br); t.frz = 1'(frz);
    t.e_en = 1'(e_en); t.e_fdfl = 1'(e_fdfl); t.e_de = 1'(e_de);
    t.e_sa = 2'(e_sa); t.e_sb = 2'(e_sb); t.e_cnt = e_cnt;
    return t;
  endfunction

  // Driver
  task automatic drive(input vec_t t);
    id_valid = t.iv; rs1_id = t.rs1; rs1use_id = t.u1; rs2_id = t.rs2; rs2use_id = t.u2;
    rd_id = t.rd; regwrite_id = t.rw; lat_id = t.lat; branch_taken_id = t.br; freeze = t.frz;
  endtask

  task automatic chk(input string nm, input int idx, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  // Compare every output of both instances against one expected record.
  task automatic check_all(input int idx, input vec_t t);
    int sat;
    sat = (t.e_cnt > 3) ? 3 : t.e_cnt;
    chk("pc_en",     idx, pc_en,     t.e_en);
    chk("fd_en",     idx, fd_en,     t.e_en);
    chk("fd_flush",  idx, fd_flush,  t.e_fdfl);
    chk("de_flush",  idx, de_flush,  t.e_de);
    chk("fwd_sel_a", idx, fwd_sel_a, t.e_sa);
    chk("fwd_sel_b", idx, fwd_sel_b, t.e_sb);
    chk("stall_cnt", idx, stall_cnt, t.e_cnt);
    chk("sat_ctrl",  idx, {s_pc_en, s_fd_en, s_fd_flush, s_de_flush, s_fwd_sel_a, s_fwd_sel_b},
        {t.e_en, t.e_en, t.e_fdfl, t.e_de, t.e_sa, t.e_sb});
    chk("sat_cnt",   idx, s_stall_cnt, sat);
  endtask

  initial begin
    vec_t h;
    // Reset
    rst = 1'b1;
    drive(mk(0,0,0,0,0,0,0,0,0,0, 1,0,0,0,0,0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    //        iv rs1 u1 rs2 u2 rd rw lat br fz | en fdfl de sa sb cnt
    tbl.push_back(mk(0, 0,0, 0,0, 0,0,0,0,0, 1,0,0,0,0,0)); // 0 reset state
    tbl.push_back(mk(1, 0,0, 0,0, 5,1,1,0,0, 1,0,0,0,0,0)); // 1 add x5
    tbl.push_back(mk(1, 5,1, 0,0, 8,1,1,0,0, 1,0,0,1,0,0)); // 2 x5 from stage 1
    tbl.push_back(mk(1, 5,1, 0,0, 0,0,1,0,0, 1,0,0,2,0,0)); // 3 x5 from stage 2
    tbl.push_back(mk(1, 0,0, 0,0, 6,1,2,0,0, 1,0,0,0,0,0)); // 4 lw x6
    tbl.push_back(mk(1, 0,1, 6,1, 0,0,1,1,0, 0,0,1,0,0,0)); // 5 beq load-use stall
    tbl.push_back(mk(1, 0,1, 6,1, 0,0,1,1,0, 1,1,0,0,2,1)); // 6 beq resolves, taken
    tbl.push_back(mk(1, 0,0, 0,0, 7,1,1,0,0, 1,0,0,0,0,1)); // 7 x7 writer
    tbl.push_back(mk(1, 0,0, 0,0, 7,1,1,0,0, 1,0,0,0,0,1)); // 8 x7 writer again
    tbl.push_back(mk(1, 7,1, 7,1, 0,0,1,0,0, 1,0,0,1,1,1)); // 9 youngest wins
    tbl.push_back(mk(1, 0,0, 0,0, 0,1,1,0,0, 1,0,0,0,0,1)); // 10 writes x0
    tbl.push_back(mk(1, 0,1, 0,1, 0,0,1,0,0, 1,0,0,0,0,1)); // 11 reads x0
    tbl.push_back(mk(1, 0,0, 0,0, 9,1,2,0,0, 1,0,0,0,0,1)); // 12 lw x9
    tbl.push_back(mk(1, 9,1, 0,0, 0,0,1,0,1, 0,0,0,0,0,1)); // 13 frozen
    tbl.push_back(mk(1, 9,1, 0,0, 0,0,1,0,1, 0,0,0,0,0,1)); // 14 frozen
    tbl.push_back(mk(1, 9,1, 0,0, 0,0,1,0,1, 0,0,0,0,0,1)); // 15 frozen
    tbl.push_back(mk(1, 9,1, 0,0, 0,0,1,0,0, 0,0,1,0,0,1)); // 16 x9 still in stage 1
    tbl.push_back(mk(1, 9,1, 0,0, 0,0,1,0,0, 1,0,0,2,0,2)); // 17 x9 from stage 2
    tbl.push_back(mk(1, 0,0, 0,0,10,1,5,0,0, 1,0,0,0,0,2)); // 18 long op x10 lat 5
    tbl.push_back(mk(1, 0,0,10,1, 0,0,1,0,0, 0,0,1,0,0,2)); // 19 stall k=1
    tbl.push_back(mk(1, 0,0,10,1, 0,0,1,0,0, 0,0,1,0,0,3)); // 20 stall k=2
    tbl.push_back(mk(1, 0,0,10,1, 0,0,1,0,0, 0,0,1,0,0,4)); // 21 stall k=3
    tbl.push_back(mk(1, 0,0,10,1, 0,0,1,0,0, 1,0,0,0,0,5)); // 22 retired, use RF
    tbl.push_back(mk(1, 0,0, 0,0,11,1,0,0,0, 1,0,0,0,0,5)); // 23 lat 0 producer
    tbl.push_back(mk(1,11,1, 0,0, 0,0,1,0,0, 1,0,0,1,0,5)); // 24 treated as lat 1
    tbl.push_back(mk(0,11,0,11,1, 0,0,0,0,0, 1,0,0,0,2,5)); // 25 unused rs1 ignored

    foreach (tbl[i]) begin
      drive(tbl[i]);
      #1;
      check_all(i, tbl[i]);
      @(negedge clk);
    end

    // Reset asserted in the middle of a load-use stall.
    drive(mk(1, 0,0, 0,0,12,1,2,0,0, 1,0,0,0,0,5));
    #1;
    check_all(100, mk(1, 0,0, 0,0,12,1,2,0,0, 1,0,0,0,0,5));
    @(negedge clk);
    h = mk(1,12,1, 0,0, 0,0,1,0,0, 0,0,1,0,0,5);
    drive(h);
    #1;
    check_all(101, h);
    #2;
    rst = 1'b1;
    #1;
    check_all(102, mk(1,12,1, 0,0, 0,0,1,0,0, 1,0,0,0,0,0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all(103, mk(1,12,1, 0,0, 0,0,1,0,0, 1,0,0,0,0,0));
    @(negedge clk);
    #1;
    check_all(104, mk(1,12,1, 0,0, 0,0,1,0,0, 1,0,0,0,0,0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
- Parametrised successor to the fixed 5-stage hazard/forwarding logic in the RV32 pipeline.
- Tracks every in-flight register-writing instruction in a shift-register scoreboard of depth NSTAGES, each entry carrying its own result latency.
- From that state it produces stall, flush and per-operand forward selects for operands read in ID, where branches resolve.
- Supports variable-latency producers (ALU, load, multi-cycle units) and an external freeze input.

Parameters:
- NSTAGES, 3, number of post-ID stages tracked (EXE=1 … WB=NSTAGES); forward mux has NSTAGES+1 inputs.
- LAT_W, 3, width of the per-instruction latency field; latency range 1..2^LAT_W-1.
- RADDR_W, 5, register address width.
- SEL_W, 2, forward select width; must satisfy 2^SEL_W ≥ NSTAGES+1.
- CNT_W, 32, width of the stall statistics counter.

Ports:
- clk  in  1  main pipeline clock
- rst  in  1  reset, asynchronous, active-high
- id_valid  in  1  ID holds a real instruction
- rs1_id  in  RADDR_W  ID source 1 address
- rs2_id  in  RADDR_W  ID source 2 address
- rs1use_id  in  1  ID reads rs1
- rs2use_id  in  1  ID reads rs2
- rd_id  in  RADDR_W  ID destination
- regwrite_id  in  1  ID writes rd
- lat_id  in  LAT_W  stages after ID until result is forwardable (1=ALU end-of-EXE, 2=load end-of-MEM)
- branch_taken_id  in  1  ID redirects PC this cycle
- freeze  in  1  external hold (multi-cycle unit busy)
- pc_en  out  1  PC register enable
- fd_en  out  1  IF/ID register enable
- fd_flush  out  1  IF/ID flush
- de_flush  out  1  ID/EX flush (bubble insert)
- fwd_sel_a  out  SEL_W  rs1 forward select: 0=register file, k=stage k result
- fwd_sel_b  out  SEL_W  rs2 forward select, same encoding
- stall_cnt  out  CNT_W  cumulative data-hazard stall cycles

Behaviour:
- Scoreboard: NSTAGES entries {v, rd, lat}; entry k describes the instruction currently in stage k.
- Reset (async): all entries v=0, stall_cnt=0. Combinationally this gives pc_en=1, fd_en=1, fd_flush=0, de_flush=0, fwd_sel_a=fwd_sel_b=0.
- Match, per used operand rs≠0: the smallest k with v_k && rd_k==rs, i.e. the youngest producer. No match or rs==0 gives select 0 and no hazard.
- Hazard: a match at k with k < lat_k means the data is not ready; set stall=1. Otherwise the select is k.
- stall = id_valid && (hazard_a || hazard_b).
- stall=1: pc_en=0, fd_en=0, de_flush=1, fd_flush=0. Entry 1 loads v=0 (bubble); entries shift k→k+1. branch_taken_id is ignored while stalled because operands are unresolved.
- No stall, branch_taken_id=1: fd_flush=1, pc_en=1, fd_en=1. Entry 1 loads the ID instruction.
- Normal advance: entry1←{id_valid&&regwrite_id&&rd_id≠0, rd_id, lat_id}; entry k+1←entry k; entry NSTAGES retires.
- freeze=1 overrides everything: pc_en=0, fd_en=0, de_flush=0, fd_flush=0, and the scoreboard holds. Forward selects are still computed. stall_cnt does not increment.
- stall_cnt increments by 1 on every non-frozen stall cycle and saturates at all-ones.
- fwd_sel outputs are combinational from the current scoreboard plus ID inputs, with zero added latency. All other state updates on the rising edge of clk.
- lat_id=0 is treated as 1. lat > NSTAGES is legal and means no forwarding: the consumer stalls until the entry retires and then reads the register file. Register-file write-before-read is required of the integrator.
- A rst assertion mid-stall clears all state immediately; the next cycle after release is a normal advance.

Decomposition:
- Shared package hazard_pkg holds the localparams for select encodings (FWD_RF=0), the LAT_ALU=1 and LAT_LOAD=2 constants, and the typedef of the scoreboard entry struct.
- One sub-module, hazard_match: combinational youngest-match finder plus ready check for one operand, instantiated twice (rs1, rs2).

Test Plan:
- add x5 (lat 1) then next-cycle add using x5 as rs1 -> no stall, fwd_sel_a=1; following cycle fwd_sel_a=2.
- lw x6 (lat 2) then beq using x6 as rs2 -> one stall (pc_en=0, de_flush=1, stall_cnt 0→1), then fwd_sel_b=2.
- Two writers of x7 in stages 1 and 2, consumer reads x7 -> fwd_sel=1 (youngest wins).
- Producer writes x0, consumer reads x0 -> fwd_sel=0, no stall.
- Stall condition with freeze=1 for 3 cycles -> pc_en=0, de_flush=0, stall_cnt unchanged, scoreboard contents identical after release.
- Taken branch with no hazard -> fd_flush=1 for 1 cycle; rst pulsed during a load-use stall -> all outputs return to reset values asynchronously.
